// File: rtl/period_meter.sv
// Measures period and high time of an asynchronous periodic input in clock_in cycles,
// publishing each result with a one-cycle valid strobe and flagging loss of signal.
module period_meter #(
  parameter int unsigned      WIDTH   = 28,
  parameter logic [WIDTH-1:0] TIMEOUT = 28'd50_000_000
) (
  input  logic             clock_in,
  input  logic             reset,
  input  logic             signal_in,
  output logic [WIDTH-1:0] period_out,
  output logic [WIDTH-1:0] high_out,
  output logic             valid,
  output logic             timeout
);

  localparam logic [WIDTH-1:0] TMO_LAST = TIMEOUT - WIDTH'(1);

  typedef enum logic {
    IDLE,
    MEASURE
  } state_e;

  state_e           state_q, state_d;
  logic             q1_q, q1_d;
  logic             q2_q, q2_d;
  logic             prev_q, prev_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic [WIDTH-1:0] high_q, high_d;
  logic             valid_q, valid_d;
  logic             timeout_q, timeout_d;

  logic rise;
  logic fall;
  logic tmo_hit;

  // Synchronizer and prev load 1 in reset so a signal already high at release is not a rise.
  always_ff @(posedge clock_in) begin
    if (reset) begin
      state_q   <= IDLE;
      q1_q      <= 1'b1;
      q2_q      <= 1'b1;
      prev_q    <= 1'b1;
      cnt_q     <= '0;
      hold_q    <= '0;
      period_q  <= '0;
      high_q    <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      q1_q      <= q1_d;
      q2_q      <= q2_d;
      prev_q    <= prev_d;
      cnt_q     <= cnt_d;
      hold_q    <= hold_d;
      period_q  <= period_d;
      high_q    <= high_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    q1_d    = signal_in;
    q2_d    = q1_q;
    prev_d  = q2_q;
    rise    = q2_q & ~prev_q;
    fall    = ~q2_q & prev_q;
    tmo_hit = (cnt_q == TMO_LAST);
  end

  always_comb begin
    state_d = state_q;
    if (rise) begin
      state_d = MEASURE;
    end else if (tmo_hit) begin
      state_d = IDLE;
    end
  end

  // A rise wins over a coincident timeout, so a period of exactly TIMEOUT is measurable.
  always_comb begin
    cnt_d     = cnt_q + WIDTH'(1);
    hold_d    = hold_q;
    period_d  = period_q;
    high_d    = high_q;
    valid_d   = 1'b0;
    timeout_d = timeout_q;
    if (rise) begin
      cnt_d = '0;
      if (state_q == MEASURE) begin
        period_d  = cnt_q + WIDTH'(1);
        high_d    = hold_q;
        valid_d   = 1'b1;
        timeout_d = 1'b0;
      end
    end else if (tmo_hit) begin
      cnt_d     = '0;
      period_d  = '0;
      high_d    = '0;
      timeout_d = 1'b1;
    end else if (fall && (state_q == MEASURE)) begin
      hold_d = cnt_q + WIDTH'(1);
    end
  end

  assign period_out = period_q;
  assign high_out   = high_q;
  assign valid      = valid_q;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_period_meter.sv
// Directed and randomized square-wave stimulus for period_meter, checked every cycle
// against a timestamp-based model of when edges are seen and what gets published.
module tb_period_meter;

  localparam int WIDTH = 28;
  localparam int TMO   = 100;

  logic             clock_in;
  logic             reset;
  logic             signal_in;
  logic [WIDTH-1:0] period_out;
  logic [WIDTH-1:0] high_out;
  logic             valid;
  logic             timeout;

  int checks = 0;
  int errors = 0;

  // Model: raw input samples per clock edge plus timestamps of the arming/last reference edge.
  logic             samp [0:8191];
  int               edge_no;
  int               ref_edge;
  int               pend_high;
  logic             armed;
  logic [WIDTH-1:0] exp_period;
  logic [WIDTH-1:0] exp_high;
  logic             exp_valid;
  logic             exp_timeout;

  int vcount;
  int tcount;

  period_meter #(
    .WIDTH  (WIDTH),
    .TIMEOUT(28'd100)
  ) dut (
    .clock_in  (clock_in),
    .reset     (reset),
    .signal_in (signal_in),
    .period_out(period_out),
    .high_out  (high_out),
    .valid     (valid),
    .timeout   (timeout)
  );

  // Free-running 10-unit clock
  initial begin
    clock_in = 1'b0;
    forever #5 clock_in = ~clock_in;
  end

  // An edge becomes visible to the measurement two clocks after it was sampled.
  task automatic modelStep(input logic r, input logic s);
    logic rise;
    logic fall;
    int   m;
    edge_no++;
    m         = edge_no;
    exp_valid = 1'b0;
    if (r) begin
      samp[m]     = 1'b1;
      samp[m - 1] = 1'b1;
      samp[m - 2] = 1'b1;
      armed       = 1'b0;
      ref_edge    = m;
      pend_high   = 0;
      exp_period  = '0;
      exp_high    = '0;
      exp_timeout = 1'b0;
    end else begin
      samp[m] = s;
      rise    = samp[m - 2] && !samp[m - 3];
      fall    = !samp[m - 2] && samp[m - 3];
      if (fall && armed) pend_high = m - ref_edge;
      if (rise) begin
        if (armed) begin
          exp_period  = WIDTH'(m - ref_edge);
          exp_high    = WIDTH'(pend_high);
          exp_valid   = 1'b1;
          exp_timeout = 1'b0;
        end
        armed    = 1'b1;
        ref_edge = m;
      end else if (m - ref_edge == TMO) begin
        exp_timeout = 1'b1;
        exp_period  = '0;
        exp_high    = '0;
        armed       = 1'b0;
        ref_edge    = m;
      end
    end
  endtask

  // Compare all outputs against the model and tally strobes seen
  task automatic checkOutput();
    checks++;
    assert (valid === exp_valid) else begin
      errors++;
      $error("[TB] FAIL valid edge=%0d got=%b exp=%b", edge_no, valid, exp_valid);
    end
    checks++;
    assert (timeout === exp_timeout) else begin
      errors++;
      $error("[TB] FAIL timeout edge=%0d got=%b exp=%b", edge_no, timeout, exp_timeout);
    end
    checks++;
    assert (period_out === exp_period) else begin
      errors++;
      $error("[TB] FAIL period_out edge=%0d got=%0d exp=%0d", edge_no, period_out, exp_period);
    end
    checks++;
    assert (high_out === exp_high) else begin
      errors++;
      $error("[TB] FAIL high_out edge=%0d got=%0d exp=%0d", edge_no, high_out, exp_high);
    end
    if (valid === 1'b1) vcount++;
    if (timeout === 1'b1) tcount++;
  endtask

  task automatic checkCount(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s got=%0d exp=%0d", tag, obs, expv);
    end
  endtask

  task automatic tick(input logic s, input logic r);
    @(negedge clock_in);
    signal_in = s;
    reset     = r;
    @(posedge clock_in);
    modelStep(r, s);
    #1;
    checkOutput();
  endtask

  task automatic holdLevel(input int n, input logic s);
    for (int i = 0; i < n; i++) tick(s, 1'b0);
  endtask

  // Square wave: high for hi cycles then low for the rest of each period
  task automatic applyStimulus(input int per, input int hi, input int n);
    for (int p = 0; p < n; p++)
      for (int c = 0; c < per; c++) tick(c < hi, 1'b0);
  endtask

  initial begin
    int per;
    int hi;
    for (int i = 0; i < 8192; i++) samp[i] = 1'b1;
    edge_no     = 3;
    ref_edge    = 3;
    pend_high   = 0;
    armed       = 1'b0;
    exp_period  = '0;
    exp_high    = '0;
    exp_valid   = 1'b0;
    exp_timeout = 1'b0;
    vcount      = 0;
    tcount      = 0;
    reset       = 1'b1;
    signal_in   = 1'b0;

    $display("[TB] reset and quiet input");
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    vcount = 0;
    tcount = 0;
    holdLevel(20, 1'b0);
    checkCount("quiet_valids", vcount, 0);
    checkCount("quiet_timeouts", tcount, 0);

    $display("[TB] P=10 H=4 then P=17 H=5");
    vcount = 0;
    applyStimulus(10, 4, 6);
    checkCount("p10_valids", vcount, 5);
    applyStimulus(17, 5, 5);

    $display("[TB] signal lost, then resume P=10");
    tcount = 0;
    holdLevel(250, 1'b0);
    checkCount("lost_timeout_high", (tcount > 0) ? 1 : 0, 1);
    applyStimulus(10, 4, 4);

    $display("[TB] P=100 at the timeout limit");
    vcount = 0;
    tcount = 0;
    applyStimulus(100, 30, 3);
    checkCount("p100_valids", vcount, 3);
    checkCount("p100_timeouts", tcount, 0);

    $display("[TB] P=101 beyond the timeout limit");
    applyStimulus(101, 30, 1);
    vcount = 0;
    tcount = 0;
    applyStimulus(101, 30, 3);
    checkCount("p101_valids", vcount, 0);
    checkCount("p101_timeout_seen", (tcount > 0) ? 1 : 0, 1);

    $display("[TB] randomized periods");
    for (int k = 0; k < 4; k++) begin
      per = $urandom_range(60, 3);
      hi  = $urandom_range(per - 1, 1);
      applyStimulus(per, hi, 4);
    end

    $display("[TB] input high through reset release, then P=12 H=6");
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b1);
    vcount = 0;
    holdLevel(5, 1'b1);
    holdLevel(3, 1'b0);
    checkCount("high_release_no_valid", vcount, 0);
    applyStimulus(12, 6, 4);

    $display("[TB] one-cycle reset mid-period");
    applyStimulus(10, 4, 2);
    holdLevel(2, 1'b1);
    tick(1'b1, 1'b1);
    holdLevel(2, 1'b1);
    holdLevel(6, 1'b0);
    vcount = 0;
    applyStimulus(10, 4, 1);
    checkCount("post_reset_arm_only", vcount, 0);
    applyStimulus(10, 4, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/period_meter.md
# period_meter

Receive-side counterpart to the clock divider. Measures the period and high time of an asynchronous periodic input (divided clock, HSYNC, VSYNC) in units of clock_in cycles, and publishes each completed measurement with a one-cycle valid strobe. Used to verify divider output and to detect and lock onto incoming sync rates. It also flags loss of signal with a timeout.

## Interface
- WIDTH, 28: width of the cycle counter and of the period/high results.
- TIMEOUT, 28'd50_000_000: maximum measurable period in clock_in cycles. No rising edge within this many cycles means signal lost. Legal range 2 .. 2^WIDTH-1.

- clock_in  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- signal_in  input  1  asynchronous signal under measurement.
- period_out  output  WIDTH  cycles between the last two detected rising edges.
- high_out  output  WIDTH  cycles from the last rising edge to the following falling edge, within the published period.
- valid  output  1  one-cycle strobe; period_out/high_out updated this cycle.
- timeout  output  1  level; signal lost, results invalid.

## Operation
- Input path: two-flop synchronizer (q1, q2) plus delayed copy prev. On reset, q1, q2 and prev all load 1, so a signal that is already high at reset release yields no spurious rise.
- Edge detection:
  - rise = q2 & ~prev
  - fall = ~q2 & prev
- State machine: IDLE, MEASURE. Reset enters IDLE.
- cnt: WIDTH-bit counter. It increments every cycle in both states, except when cleared.
- hold: WIDTH-bit register holding the pending high time.
- IDLE:
  - On rise: cnt <= 0, go to MEASURE. No valid and no output update, because the first edge only arms the block.
- MEASURE:
  - On fall: hold <= cnt+1.
  - On rise: period_out <= cnt+1, high_out <= hold, valid <= 1, timeout <= 0, cnt <= 0. Stay in MEASURE.
- Timeout applies in either state. When cnt == TIMEOUT-1 and there is no rise:
  - timeout <= 1, period_out <= 0, high_out <= 0, cnt <= 0, state <= IDLE.
  - timeout stays high until the next valid measurement.
- Simultaneous events:
  - A rise in the same cycle as the timeout condition is a rise; the timeout does not fire. Period = TIMEOUT is therefore measurable.
  - rise and fall cannot occur in the same cycle.
- Width rules: cnt never exceeds TIMEOUT-1, so cnt+1 never overflows WIDTH and no saturation logic is needed.
- A fall before any rise in MEASURE is impossible. A fall in IDLE is ignored.

## Timing
- Reset values: period_out = 0, high_out = 0, valid = 0, timeout = 0, cnt = 0, hold = 0, state IDLE.
- Latency: signal_in rise sampled at clock edge n gives:
  - q2 = 1 after edge n+1
  - valid high after edge n+2, for exactly one cycle
  - Falls have the same 2-cycle latency, so the latencies cancel in both measurements.
- For a steady input of period P and high time H (P ≤ TIMEOUT):
  - first valid on the second detected rise after arming
  - then one valid every P cycles with period_out = P, high_out = H
- Timeout asserts TIMEOUT cycles after the last rise (or after the arming rise, or after the previous timeout). It then re-fires every TIMEOUT cycles while the signal is absent; outputs stay 0.
- Reset mid-measurement: all state returns to reset values on the next edge. The pending hold value is discarded and the next rise only arms.

## Test plan
- Reset, signal_in = 0 for 20 cycles -> period_out = 0, high_out = 0, valid = 0, timeout = 0 throughout.
- TIMEOUT = 100; square wave P = 10, H = 4 from cycle 5 -> first rise produces no valid; valid pulses every 10 cycles with period_out = 10, high_out = 4; each valid is 2 cycles after the corresponding sampled rise.
- Change to P = 17, H = 5 mid-stream -> the first valid after the change reports the exact transitional interval; all later valids report 17 / 5 with no missed strobes.
- TIMEOUT = 100; P = 10 then hold signal_in low -> timeout rises exactly 100 cycles after the last rise, outputs cleared to 0. Resume P = 10 -> first rise produces no valid; second rise gives valid, period_out = 10, timeout deasserts.
- TIMEOUT = 100; P = 100 -> valid every 100 cycles with period_out = 100 and timeout never asserts. With P = 101 -> timeout asserts and valid never asserts.
- signal_in high through reset release, then P = 12, H = 6 -> no edge at release; first valid only after two real rises, with period_out = 12, high_out = 6.
- Assert reset for 1 cycle midway through a period -> all outputs 0 the next cycle; valid resumes only after two further rises.
